// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: RGB-LCD raster timing (hsync/vsync/de, pixel clock, x/y) from a divided CLK_SYS.
// Ports: CLK_SYS clock; rst async active-low; en run/stop-at-frame-end; busy while running;
// pix_ce first cycle of each pixel; lcd_clk pixel clock rising mid-pixel; hsync/vsync per SYNC_POL;
// de active-area flag; x/y active coordinates (0 when de=0); line_start/frame_start on pix_ce of h=0 / h=0,v=0.
module lcd_timing_gen #(
  parameter int PIX_DIV  = 10,
  parameter int H_ACTIVE = 480,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 43,
  parameter int H_FP     = 8,
  parameter int V_ACTIVE = 272,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 12,
  parameter int V_FP     = 8,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       CLK_SYS,
  input  logic       rst,
  input  logic       en,
  output logic       busy,
  output logic       pix_ce,
  output logic       lcd_clk,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);
  localparam int HT  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int VT  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HA0 = H_SYNC + H_BP;
  localparam int VA0 = V_SYNC + V_BP;
  localparam logic [7:0]  D_MAX  = 8'(PIX_DIV - 1);
  localparam logic [7:0]  D_HALF = 8'(PIX_DIV / 2);
  localparam logic [9:0]  H_MAX  = 10'(HT - 1);
  localparam logic [9:0]  V_MAX  = 10'(VT - 1);
  localparam logic [9:0]  H_S    = 10'(H_SYNC);
  localparam logic [9:0]  V_S    = 10'(V_SYNC);
  localparam logic [9:0]  H_A0   = 10'(HA0);
  localparam logic [9:0]  V_A0   = 10'(VA0);
  localparam logic [10:0] H_A    = 11'(H_ACTIVE);
  localparam logic [10:0] V_A    = 11'(V_ACTIVE);

  if (HT > 1024 || VT > 1024 || PIX_DIV < 2 || PIX_DIV > 255) begin : g_bad_params
    $error("lcd_timing_gen: HT/VT must be <= 1024 and PIX_DIV in 2..255");
  end

  typedef enum logic {IDLE, RUN} state_t;
  state_t st;
  logic [7:0] div, div_n;
  logic [9:0] h, h_n, v, v_n, xo, yo;
  logic run_n, step, d_wrap, h_wrap, v_wrap, hin, vin, act, pe;

  // Outputs are registered from the next-state values, so they line up with the counters
  // while keeping every output a flop.
  always_comb begin
    d_wrap = div == D_MAX;
    h_wrap = h == H_MAX;
    v_wrap = v == V_MAX;
    run_n  = (st == IDLE) ? en : !(d_wrap && h_wrap && v_wrap && !en);
    step   = st == RUN && run_n;
    div_n  = (step && !d_wrap) ? div + 8'd1 : 8'd0;
    h_n    = !step ? 10'd0 : !d_wrap ? h : h_wrap ? 10'd0 : h + 10'd1;
    v_n    = !step ? 10'd0 : !(d_wrap && h_wrap) ? v : v_wrap ? 10'd0 : v + 10'd1;
    xo     = h_n - H_A0;
    yo     = v_n - V_A0;
    hin    = h_n >= H_A0 && {1'b0, xo} < H_A;
    vin    = v_n >= V_A0 && {1'b0, yo} < V_A;
    act    = run_n && hin && vin;
    pe     = run_n && div_n == 8'd0;
  end

  always_ff @(posedge CLK_SYS or negedge rst) begin
    if (!rst) begin
      st          <= IDLE;
      div         <= 8'd0;
      h           <= 10'd0;
      v           <= 10'd0;
      busy        <= 1'b0;
      pix_ce      <= 1'b0;
      lcd_clk     <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= 10'd0;
      y           <= 10'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      st          <= run_n ? RUN : IDLE;
      div         <= div_n;
      h           <= h_n;
      v           <= v_n;
      busy        <= run_n;
      pix_ce      <= pe;
      lcd_clk     <= run_n && div_n >= D_HALF;
      hsync       <= (run_n && h_n < H_S) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (run_n && v_n < V_S) ? SYNC_POL : ~SYNC_POL;
      de          <= act;
      x           <= act ? xo : 10'd0;
      y           <= act ? yo : 10'd0;
      line_start  <= pe && h_n == 10'd0;
      frame_start <= pe && h_n == 10'd0 && v_n == 10'd0;
    end
  end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: scoreboard bench for lcd_timing_gen with a frame-position reference model.
module tb_lcd_timing_gen;
  localparam int D   = 4;
  localparam int HA  = 6;
  localparam int HS  = 2;
  localparam int HBP = 2;
  localparam int HFP = 1;
  localparam int VA  = 4;
  localparam int VS  = 1;
  localparam int VBP = 2;
  localparam int VFP = 1;
  localparam bit POL = 1'b0;
  localparam int HT  = HS + HBP + HA + HFP;
  localparam int VT  = VS + VBP + VA + VFP;
  localparam int FRAME = D * HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic busy, pix_ce, lcd_clk, hsync, vsync, de, line_start, frame_start;
  logic [9:0] x, y;
  logic [27:0] dut_v;
  logic [27:0] sb[$];
  int n_tests = 0;
  int n_fail = 0;

  lcd_timing_gen #(
    .PIX_DIV(D), .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HBP), .H_FP(HFP),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VBP), .V_FP(VFP), .SYNC_POL(POL)
  ) dut (
    .CLK_SYS(clk), .rst(rst), .en(en), .busy(busy), .pix_ce(pix_ce), .lcd_clk(lcd_clk),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
  );

  assign dut_v = {busy, pix_ce, lcd_clk, hsync, vsync, de, line_start, frame_start, x, y};

  always #5 clk = ~clk;

  // Expected outputs from run flag and cycle offset t within the frame.
  function automatic logic [27:0] exp_out(bit r, int t);
    int dv, px, hh, vv;
    bit ce, act;
    logic [9:0] ex, ey;
    dv  = t % D;
    px  = t / D;
    hh  = px % HT;
    vv  = px / HT;
    ce  = r && dv == 0;
    act = r && hh >= HS + HBP && hh < HS + HBP + HA && vv >= VS + VBP && vv < VS + VBP + VA;
    ex  = act ? 10'(hh - (HS + HBP)) : 10'd0;
    ey  = act ? 10'(vv - (VS + VBP)) : 10'd0;
    return {r, ce, r && dv >= D / 2, (r && hh < HS) ? POL : !POL, (r && vv < VS) ? POL : !POL,
            act, ce && hh == 0, ce && px == 0, ex, ey};
  endfunction

  task automatic cmp(string name, logic [27:0] got, logic [27:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  initial begin : model
    bit m_run;
    int m_t;
    m_run = 1'b0;
    m_t = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_run = 1'b0;
        m_t = 0;
      end else if (!m_run) begin
        if (en) begin
          m_run = 1'b1;
          m_t = 0;
        end
      end else if (m_t == FRAME - 1) begin
        m_t = 0;
        if (!en) m_run = 1'b0;
      end else begin
        m_t++;
      end
      sb.push_back(exp_out(m_run, m_t));
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_empty at %0t: got no entry expected one", $time);
      end else begin
        cmp("raster", dut_v, sb.pop_front());
      end
    end
  end

  task automatic pulse_reset(int len);
    rst = 1'b0;
    #1;
    cmp("async_reset", dut_v, exp_out(1'b0, 0));
    repeat (len) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : stim
    int k;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (2 * FRAME + 10) @(negedge clk);
    en = 1'b0;
    repeat (FRAME + 20) @(negedge clk);
    en = 1'b1;
    repeat (100) @(negedge clk);
    en = 1'b0;
    repeat (50) @(negedge clk);
    en = 1'b1;
    repeat (FRAME + 37) @(negedge clk);
    pulse_reset(2);
    repeat (FRAME / 2) @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 9));
      if (k == 0) pulse_reset(int'($urandom_range(1, 3)));
      else en = k > 3;
      repeat (int'($urandom_range(1, FRAME))) @(negedge clk);
    end
    en = 1'b0;
    repeat (FRAME + 5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
